mem_ctrl: RTL and testbench

Request/response memory controller that sits directly upstream of the data RAM and drives its ports (`data`, `read_addr`, `write_addr`, `we`) and consumes its registered output `q`. It turns single CPU load/store requests, given as 32-bit byte addresses, into correctly timed RAM accesses. It absorbs the RAM's one-cycle read latency and never issues a read and a write in the same cycle, so the RAM's read-during-write (old-data) behaviour is never exposed. Misaligned and out-of-range accesses are rejected with an error response and never reach the RAM.

---
 rtl/mem_ctrl_if.sv | 35 +++
 rtl/mem_ctrl.sv | 95 +++++++++
 tb/tb_mem_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// CPU request/response channel plus the data-RAM port bundle for mem_ctrl.
// The slave modport is the controller; master is the CPU/RAM environment side.
interface mem_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    logic [DATA_WIDTH-1:0] ram_data;
    logic [ADDR_WIDTH-1:0] ram_read_addr;
    logic [ADDR_WIDTH-1:0] ram_write_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, ram_q,
        output req_ready, resp_valid, resp_rdata, resp_err,
               ram_data, ram_read_addr, ram_write_addr, ram_we
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, ram_q,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               ram_data, ram_read_addr, ram_write_addr, ram_we
    );
endinterface

// File: rtl/mem_ctrl.sv
// Single-outstanding load/store controller in front of a 1-cycle-latency RAM.
// Latency: store 2, load 3, error 1 cycles; req_ready only in IDLE, RESP holds until resp_ready.
module mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic         clock,
    input  logic         reset_n,
    mem_ctrl_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, WR, RD1, RD2, RESP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  addr_err;

    assign word_idx = bus.req_addr[ADDR_WIDTH+1:2];
    assign addr_err = (|bus.req_addr[1:0]) || (|bus.req_addr[31:ADDR_WIDTH+2]);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            raddr_q      <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            raddr_q      <= raddr_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        raddr_d      = raddr_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (addr_err) begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = RESP;
                    end else if (bus.req_we) begin
                        waddr_d = word_idx;
                        wdata_d = bus.req_wdata;
                        state_d = WR;
                    end else begin
                        raddr_d = word_idx;
                        state_d = RD1;
                    end
                end
            end
            WR: begin
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
                state_d      = RESP;
            end
            RD1: state_d = RD2;
            // RAM output register is valid here, one cycle after it sampled the address.
            RD2: begin
                resp_err_d   = 1'b0;
                resp_rdata_d = bus.ram_q;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready      = (state_q == IDLE);
    assign bus.resp_valid     = (state_q == RESP);
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.ram_we         = (state_q == WR);
    assign bus.ram_read_addr  = raddr_q;
    assign bus.ram_write_addr = waddr_q;
    assign bus.ram_data       = wdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl with a behavioural RAM (registered q, old-data on read-during-write).
module tb_mem_ctrl;
    localparam int DW = 32;
    localparam int AW = 6;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q_r;
    initial for (int i = 0; i < (1<<AW); i++) ram[i] = i;
    always @(posedge clock) begin
        if (bus.ram_we) ram[bus.ram_write_addr] <= bus.ram_data;
        ram_q_r <= ram[bus.ram_read_addr];
    end
    assign bus.ram_q = ram_q_r;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input exp_t e, input int hold);
        int   lat;
        int   wes;
        exp_t got;
        @(negedge clock);
        bus.resp_ready = (hold == 0);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clock);
        sb.push_back(e);
        @(negedge clock);
        bus.req_valid = 1'b0;
        lat = 1;
        wes = 0;
        while (!bus.resp_valid && lat < 20) begin
            if (bus.ram_we) begin
                wes++;
                chk("ram_write_addr", {26'd0, bus.ram_write_addr}, {26'd0, addr[7:2]});
                chk("ram_data", bus.ram_data, wdata);
            end
            chk("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
        got = sb.pop_front();
        if (!bus.resp_valid) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: no resp_valid after %0d cycles, expected after %0d", lat, got.lat);
            bus.resp_ready = 1'b1;
            return;
        end
        chk("latency", lat, got.lat);
        chk("resp_rdata", bus.resp_rdata, got.rdata);
        chk("resp_err", {31'd0, bus.resp_err}, {31'd0, got.err});
        chk("ram_we_cycles", wes, got.wes);
        chk("ram_we_in_resp", {31'd0, bus.ram_we}, 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clock);
            @(negedge clock);
            chk("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("bp_resp_rdata", bus.resp_rdata, got.rdata);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("done_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("done_req_ready", {31'd0, bus.req_ready}, 32'd1);
    endtask

    vec_t vecs [10];
    exp_t ex;

    initial begin
        vecs[0] = '{1'b1, 32'h0000_000C, 32'hDEAD_BEEF, '{32'h0, 1'b0, 2, 1}};
        vecs[1] = '{1'b0, 32'h0000_000C, 32'h0,         '{32'hDEAD_BEEF, 1'b0, 3, 0}};
        vecs[2] = '{1'b0, 32'h0000_0008, 32'h0,         '{32'h2, 1'b0, 3, 0}};
        vecs[3] = '{1'b0, 32'h0000_000D, 32'h0,         '{32'h0, 1'b1, 1, 0}};
        vecs[4] = '{1'b1, 32'h0000_0100, 32'h5555_AAAA, '{32'h0, 1'b1, 1, 0}};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         '{32'h0, 1'b0, 3, 0}};
        vecs[6] = '{1'b1, 32'h0000_00FC, 32'h1234_5678, '{32'h0, 1'b0, 2, 1}};
        vecs[7] = '{1'b0, 32'h0000_00FC, 32'h0,         '{32'h1234_5678, 1'b0, 3, 0}};
        vecs[8] = '{1'b1, 32'h0000_0006, 32'hFFFF_FFFF, '{32'h0, 1'b1, 1, 0}};
        vecs[9] = '{1'b0, 32'h8000_0000, 32'h0,         '{32'h0, 1'b1, 1, 0}};

        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rst_ram_read_addr", {26'd0, bus.ram_read_addr}, 32'd0);
        chk("rst_ram_write_addr", {26'd0, bus.ram_write_addr}, 32'd0);
        chk("rst_ram_data", bus.ram_data, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].e, 0);

        // Load response held off by resp_ready low for 5 cycles.
        ex = '{32'hDEAD_BEEF, 1'b0, 3, 0};
        run_req(1'b0, 32'h0000_000C, 32'h0, ex, 5);

        // Reset while the load sits in RD1: the response must never appear.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0008;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        chk("rd1_req_ready", {31'd0, bus.req_ready}, 32'd0);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        chk("rd1rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rd1rst_read_addr", {26'd0, bus.ram_read_addr}, 32'd0);
        begin
            int seen = 0;
            for (int k = 0; k < 6; k++) begin
                if (bus.resp_valid) seen++;
                @(posedge clock);
                @(negedge clock);
            end
            chk("rd1rst_no_resp", seen, 0);
        end

        // Reset while the store sits in WR: the RAM write still lands.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0014;
        bus.req_wdata = 32'hCAFE_F00D;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        chk("wr_ram_we", {31'd0, bus.ram_we}, 32'd1);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        chk("wrrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("wrrst_ram_we", {31'd0, bus.ram_we}, 32'd0);
        ex = '{32'hCAFE_F00D, 1'b0, 3, 0};
        run_req(1'b0, 32'h0000_0014, 32'h0, ex, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end
endmodule
